// File: rtl/msj_sequencer_pkg.sv
// Shared types and register map for the MSJ setpoint sequencer.
package msj_sequencer_pkg;

  // Width of the dwell field as stored in the waypoint buffer.
  localparam int unsigned WP_DWELL_WIDTH = 16;

  typedef enum logic [7:0] {
    IDLE  = 8'd0,
    FETCH = 8'd1,
    APPLY = 8'd2,
    DWELL = 8'd3,
    NEXT  = 8'd4
  } state_t;

  typedef struct packed {
    logic [7:0]                motor;
    logic [31:0]               sp;
    logic [WP_DWELL_WIDTH-1:0] dwell;
  } waypoint_t;

  // Write selects (address[15:8])
  localparam logic [7:0] SEL_SETPOINT = 8'h00;
  localparam logic [7:0] SEL_PUSH     = 8'h01;
  localparam logic [7:0] SEL_CONTROL  = 8'h02;

  // Read selects (address[15:8])
  localparam logic [7:0] SEL_STATUS   = 8'h00;
  localparam logic [7:0] SEL_INDEX    = 8'h01;
  localparam logic [7:0] SEL_DWELL    = 8'h02;

  localparam logic [31:0] READ_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/msj_setpoint_sequencer_waypoint_buffer.sv
// Waypoint RAM with read/write pointers, fill count and registered read port.
module waypoint_buffer
  import msj_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  waypoint_t     push_data,
  input  logic          pop,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output waypoint_t     rd_data,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full_c
);

  waypoint_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;

  assign full_c = (count == CW'(DEPTH));

  // Pointer and fill bookkeeping; a push coinciding with clear lands in slot 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array write.
  always_ff @(posedge clock) begin
    if (push) mem[clear ? '0 : wr_ptr] <= push_data;
  end

  // One-cycle registered read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/msj_setpoint_sequencer.sv
// Timed setpoint waypoint player for the MSJ PD controller bank.
// Optional build macro: TRAJECTORY_LOOP_EN (replay the list instead of consuming it).
module msj_setpoint_sequencer
  import msj_sequencer_pkg::*;
#(
  parameter int unsigned NUMBER_OF_MOTORS = 6,
  parameter int unsigned DEPTH            = 64,
  parameter int unsigned DWELL_WIDTH      = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [15:0]                 address,
  input  logic                        write,
  input  logic [31:0]                 writedata,
  input  logic                        read,
  output logic [31:0]                 readdata,
  output logic                        waitrequest,
  input  logic [NUMBER_OF_MOTORS-1:0] cycle_i,
  input  logic                        emergency_off,
  output logic                        sp_valid_o,
  output logic [7:0]                  sp_motor_o,
  output logic [31:0]                 sp_value_o,
  output logic                        busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef TRAJECTORY_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_t        state, state_next;
  logic [31:0]   staged_sp;
  logic          overflow;
  logic          start_q;
  logic          rd_ack;
  logic [AW-1:0] play_idx;
  logic [DWELL_WIDTH-1:0] dwell_cnt;

  logic          wr_stage, wr_push, wr_ctrl, ctrl_stop, ctrl_clear, ctrl_start;
  logic          motor_ok, push_ok, abort_c, hit_c, pop_c, rd_en_c, strobe_c;
  logic [NUMBER_OF_MOTORS-1:0] motor_sel;
  logic [AW-1:0] rd_ptr, rd_addr;
  logic [CW-1:0] fill, fill_after_push;
  logic          full_c;
  logic [31:0]   rd_value_c;
  waypoint_t     push_data, rd_data;

  // Avalon write decode.
  always_comb begin
    wr_stage   = write && (address[15:8] == SEL_SETPOINT);
    wr_push    = write && (address[15:8] == SEL_PUSH);
    wr_ctrl    = write && (address[15:8] == SEL_CONTROL);
    ctrl_start = wr_ctrl && writedata[0];
    ctrl_stop  = wr_ctrl && writedata[1];
    ctrl_clear = wr_ctrl && writedata[2];
    motor_ok   = address[7:0] < 8'(NUMBER_OF_MOTORS);
    push_ok    = wr_push && motor_ok && (!full_c || pop_c || ctrl_clear);
    abort_c    = emergency_off || ctrl_stop || ctrl_clear;
    push_data  = '{motor: address[7:0], sp: staged_sp,
                   dwell: WP_DWELL_WIDTH'(writedata[DWELL_WIDTH-1:0])};
    fill_after_push = fill + CW'(push_ok);
  end

  // Dwell strobe select for the motor currently being played.
  always_comb begin
    motor_sel = '0;
    for (int unsigned i = 0; i < NUMBER_OF_MOTORS; i++) begin
      motor_sel[i] = (sp_motor_o == 8'(i));
    end
    hit_c = |(cycle_i & motor_sel);
  end

  // Staged setpoint, overflow flag and delayed start request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      staged_sp <= '0;
      overflow  <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      start_q <= ctrl_start;
      if (wr_stage) staged_sp <= writedata;
      if (ctrl_clear)                            overflow <= 1'b0;
      else if (wr_push && motor_ok && !push_ok)  overflow <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state; stop, clear and emergency_off win from every state.
  always_comb begin
    state_next = state;
    if (abort_c) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_q && (fill != '0)) state_next = FETCH;
        FETCH:   state_next = APPLY;
        APPLY:   state_next = (DWELL_WIDTH'(rd_data.dwell) == '0) ? NEXT : DWELL;
        DWELL:   if (hit_c && (dwell_cnt == DWELL_WIDTH'(1))) state_next = NEXT;
        NEXT: begin
          if (LOOP_EN) state_next = FETCH;
          else         state_next = ((fill > CW'(1)) || push_ok) ? FETCH : IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM outputs: buffer read, pop and setpoint strobe request.
  always_comb begin
    rd_en_c  = 1'b0;
    pop_c    = 1'b0;
    strobe_c = 1'b0;
    case (state)
      FETCH:   rd_en_c  = 1'b1;
      APPLY:   strobe_c = !abort_c;
      NEXT:    pop_c    = !abort_c && !LOOP_EN;
      default: ;
    endcase
  end

  // In loop mode the list is addressed relative to the unmoving read pointer.
  assign rd_addr = LOOP_EN ? (rd_ptr + play_idx) : rd_ptr;

  // Setpoint strobe, latched waypoint, dwell counter, play index and busy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp_valid_o <= 1'b0;
      sp_motor_o <= '0;
      sp_value_o <= '0;
      busy_o     <= 1'b0;
      dwell_cnt  <= '0;
      play_idx   <= '0;
    end else begin
      sp_valid_o <= strobe_c;
      busy_o     <= (state_next != IDLE);
      if (strobe_c) begin
        sp_motor_o <= rd_data.motor;
        sp_value_o <= rd_data.sp;
        dwell_cnt  <= DWELL_WIDTH'(rd_data.dwell);
      end else if ((state == DWELL) && hit_c && !abort_c) begin
        dwell_cnt <= dwell_cnt - DWELL_WIDTH'(1);
      end
      if (ctrl_clear || ((state == IDLE) && (state_next == FETCH))) begin
        play_idx <= '0;
      end else if ((state == NEXT) && !abort_c) begin
        if (LOOP_EN && ((CW'(play_idx) + CW'(1)) >= fill_after_push)) play_idx <= '0;
        else                                                         play_idx <= play_idx + AW'(1);
      end
    end
  end

  // Read mux.
  always_comb begin
    case (address[15:8])
      SEL_STATUS: rd_value_c = {8'(state), overflow, emergency_off, 6'b0, 16'(fill)};
      SEL_INDEX:  rd_value_c = 32'(play_idx);
      SEL_DWELL:  rd_value_c = 32'(dwell_cnt);
      default:    rd_value_c = READ_DEFAULT;
    endcase
  end

  // Two-cycle read: wait on the first cycle, data on the second.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ack   <= 1'b0;
      readdata <= '0;
    end else begin
      rd_ack <= read && !rd_ack;
      if (read && !rd_ack) readdata <= rd_value_c;
    end
  end

  assign waitrequest = read && !rd_ack;

  waypoint_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clock     (clock),
    .reset     (reset),
    .clear     (ctrl_clear),
    .push      (push_ok),
    .push_data (push_data),
    .pop       (pop_c),
    .rd_en     (rd_en_c),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_ptr    (rd_ptr),
    .count     (fill),
    .full_c    (full_c)
  );

endmodule

// File: tb/tb_msj_setpoint_sequencer.sv
// Self-checking bench for msj_setpoint_sequencer (default: consuming FIFO build).
module tb_msj_setpoint_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [5:0]  cycle_i;
  logic        emergency_off;
  logic        sp_valid_o;
  logic [7:0]  sp_motor_o;
  logic [31:0] sp_value_o;
  logic        busy_o;

  msj_setpoint_sequencer dut (
    .clock(clock), .reset(reset), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata),
    .waitrequest(waitrequest), .cycle_i(cycle_i), .emergency_off(emergency_off),
    .sp_valid_o(sp_valid_o), .sp_motor_o(sp_motor_o), .sp_value_o(sp_value_o),
    .busy_o(busy_o)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [7:0] motor; logic [31:0] value; int c; } strobe_t;
  strobe_t got[$];
  always @(negedge clock) if (!reset && sp_valid_o) got.push_back('{sp_motor_o, sp_value_o, cyc});

  typedef struct { logic [7:0] motor; logic [31:0] value; } wp_t;
  wp_t model_q[$];

  typedef struct { bit is_wr; logic [15:0] a; logic [31:0] d; logic [31:0] exp; string nm; } vec_t;
  vec_t tbl[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] status(int st, bit ovf, bit emg, int fill);
    return {8'(st), ovf, emg, 6'b0, 16'(fill)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic av_write(input logic [15:0] a, input logic [31:0] d, output int t);
    @(negedge clock);
    address = a; writedata = d; write = 1'b1;
    @(negedge clock);
    write = 1'b0;
    t = cyc;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    int t;
    av_write(a, d, t);
  endtask

  task automatic push_wp(input logic [7:0] m, input logic [31:0] sp, input logic [15:0] dw);
    wr(16'h0000, sp);
    wr({8'h01, m}, 32'(dw));
  endtask

  task automatic av_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clock);
    address = a; read = 1'b1;
    #1;
    chk("waitrequest_first_cycle", 32'(waitrequest), 32'd1);
    @(negedge clock);
    chk("waitrequest_second_cycle", 32'(waitrequest), 32'd0);
    d = readdata;
    read = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d;
    av_read(a, d);
    chk(nm, d, exp);
  endtask

  task automatic pulse(input logic [5:0] mask);
    @(negedge clock);
    cycle_i = mask;
    @(negedge clock);
    cycle_i = '0;
  endtask

  task automatic wait_cyc(input int target);
    int k = 0;
    while (cyc < target && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (cyc < target) begin
      n_checks++; n_fail++;
      $display("FAIL wait_cyc timeout: at %0d, wanted %0d", cyc, target);
    end
  endtask

  initial begin
    int t, base;
    reset = 1'b1; address = '0; write = 1'b0; writedata = '0; read = 1'b0;
    cycle_i = '0; emergency_off = 1'b0;

    tbl.push_back('{0, 16'h0000, 32'h0, status(0,0,0,0), "reset_status"});
    tbl.push_back('{0, 16'h0100, 32'h0, 32'h0,           "reset_index"});
    tbl.push_back('{0, 16'h0200, 32'h0, 32'h0,           "reset_dwell"});
    tbl.push_back('{0, 16'h0300, 32'h0, 32'hDEADBEEF,    "bad_select_03"});
    tbl.push_back('{0, 16'hFF05, 32'h0, 32'hDEADBEEF,    "bad_select_ff"});
    tbl.push_back('{1, 16'h0000, 32'h1234, 32'h0,        ""});
    tbl.push_back('{1, 16'h0107, 32'h5, 32'h0,           ""});
    tbl.push_back('{0, 16'h0000, 32'h0, status(0,0,0,0), "push_motor7_dropped"});
    tbl.push_back('{1, 16'h0106, 32'h5, 32'h0,           ""});
    tbl.push_back('{0, 16'h0000, 32'h0, status(0,0,0,0), "push_motor6_dropped"});
    tbl.push_back('{1, 16'h0105, 32'h5, 32'h0,           ""});
    tbl.push_back('{0, 16'h0000, 32'h0, status(0,0,0,1), "push_motor5_ok"});
    tbl.push_back('{1, 16'h0200, 32'h4, 32'h0,           ""});
    tbl.push_back('{0, 16'h0000, 32'h0, status(0,0,0,0), "clear_after_push"});

    repeat (3) @(negedge clock);
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_waitrequest", 32'(waitrequest), 32'h0);
    chk("reset_sp_valid", 32'(sp_valid_o), 32'h0);
    chk("reset_sp_motor", 32'(sp_motor_o), 32'h0);
    chk("reset_sp_value", sp_value_o, 32'h0);
    chk("reset_busy", 32'(busy_o), 32'h0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].is_wr) wr(tbl[i].a, tbl[i].d);
      else              rd_chk(tbl[i].nm, tbl[i].a, tbl[i].exp);
    end

    // Start with an empty buffer is ignored.
    base = got.size();
    wr(16'h0200, 32'h1);
    repeat (5) @(negedge clock);
    chk("empty_start_busy", 32'(busy_o), 32'h0);
    chk("empty_start_strobes", 32'(got.size() - base), 32'h0);

    // Single waypoint, dwell 3 counted on motor 2 only.
    push_wp(8'd2, 32'd1000, 16'd3);
    base = got.size();
    av_write(16'h0200, 32'h1, t);
    wait_cyc(t + 4);
    chk("t1_strobe_count", 32'(got.size() - base), 32'h1);
    if (got.size() > base) begin
      chk("t1_motor", 32'(got[base].motor), 32'd2);
      chk("t1_value", got[base].value, 32'd1000);
      chk("t1_latency", 32'(got[base].c - t), 32'd3);
    end
    rd_chk("t1_dwell_loaded", 16'h0200, 32'd3);
    repeat (3) pulse(6'b000001);
    rd_chk("t1_dwell_other_motor", 16'h0200, 32'd3);
    chk("t1_busy_dwell", 32'(busy_o), 32'h1);
    repeat (2) pulse(6'b000100);
    rd_chk("t1_dwell_after_two", 16'h0200, 32'd1);
    pulse(6'b000100);
    chk("t1_busy_next", 32'(busy_o), 32'h1);
    @(negedge clock);
    chk("t1_busy_idle", 32'(busy_o), 32'h0);
`ifndef TRAJECTORY_LOOP_EN
    rd_chk("t1_status_done", 16'h0000, status(0,0,0,0));
    chk("t1_single_strobe", 32'(got.size() - base), 32'h1);
`else
    wr(16'h0200, 32'h4);
`endif

    // Overflow at DEPTH, then clear.
    wr(16'h0000, 32'd7);
    for (int i = 0; i < 64; i++) wr(16'h0100, 32'd0);
    rd_chk("full_status", 16'h0000, status(0,0,0,64));
    wr(16'h0101, 32'd0);
    rd_chk("overflow_status", 16'h0000, status(0,1,0,64));
    wr(16'h0200, 32'h4);
    rd_chk("overflow_cleared", 16'h0000, status(0,0,0,0));

`ifndef TRAJECTORY_LOOP_EN
    // Two dwell-0 waypoints: strobes 3 cycles apart.
    push_wp(8'd3, -32'sd5, 16'd0);
    push_wp(8'd4, 32'd77, 16'd0);
    base = got.size();
    av_write(16'h0200, 32'h1, t);
    wait_cyc(t + 6);
    chk("d0_busy_before_end", 32'(busy_o), 32'h1);
    @(negedge clock);
    chk("d0_busy_end", 32'(busy_o), 32'h0);
    @(negedge clock);
    chk("d0_strobe_count", 32'(got.size() - base), 32'd2);
    if (got.size() >= base + 2) begin
      chk("d0_first_latency", 32'(got[base].c - t), 32'd3);
      chk("d0_gap", 32'(got[base+1].c - got[base].c), 32'd3);
      chk("d0_first_value", got[base].value, 32'hFFFF_FFFB);
      chk("d0_second_motor", 32'(got[base+1].motor), 32'd4);
    end
`endif

    // Emergency during dwell.
    push_wp(8'd1, 32'd55, 16'd5);
    base = got.size();
    av_write(16'h0200, 32'h1, t);
    wait_cyc(t + 4);
    pulse(6'b000010);
    @(negedge clock);
    emergency_off = 1'b1;
    @(negedge clock);
    chk("emg_busy", 32'(busy_o), 32'h0);
    rd_chk("emg_status", 16'h0000, status(0,0,1,1));
    wr(16'h0200, 32'h1);
    repeat (6) @(negedge clock);
    chk("emg_start_blocked", 32'(busy_o), 32'h0);
    chk("emg_strobes", 32'(got.size() - base), 32'h1);
    emergency_off = 1'b0;
    wr(16'h0200, 32'h4);
    rd_chk("emg_cleared", 16'h0000, status(0,0,0,0));

    // Reset mid-playback.
    push_wp(8'd5, 32'd9, 16'd5);
    push_wp(8'd5, 32'd10, 16'd5);
    av_write(16'h0200, 32'h1, t);
    wait_cyc(t + 4);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("reset_mid_busy", 32'(busy_o), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    rd_chk("reset_mid_status", 16'h0000, status(0,0,0,0));

`ifndef TRAJECTORY_LOOP_EN
    // Randomized push/playback against a queue model.
    for (int it = 0; it < 5; it++) begin
      int n, k;
      model_q.delete();
      n = $urandom_range(1, 12);
      for (int j = 0; j < n; j++) begin
        logic [7:0]  m;
        logic [31:0] sp;
        m  = 8'($urandom_range(0, 7));
        sp = $urandom;
        push_wp(m, sp, 16'($urandom_range(0, 3)));
        if (m < 6) model_q.push_back('{m, sp});
      end
      rd_chk("rand_fill", 16'h0000, status(0,0,0,model_q.size()));
      base = got.size();
      wr(16'h0200, 32'h1);
      k = 0;
      while (k < 4000 && (k < 4 || busy_o)) begin
        @(negedge clock);
        cycle_i = 6'($urandom_range(0, 63));
        k++;
      end
      cycle_i = '0;
      @(negedge clock);
      chk("rand_done_busy", 32'(busy_o), 32'h0);
      chk("rand_strobe_count", 32'(got.size() - base), 32'(model_q.size()));
      for (int j = 0; j < model_q.size() && base + j < got.size(); j++) begin
        chk("rand_motor", 32'(got[base+j].motor), 32'(model_q[j].motor));
        chk("rand_value", got[base+j].value, model_q[j].value);
      end
      rd_chk("rand_final_status", 16'h0000, status(0,0,0,0));
    end
`else
    // Loop playback repeats A,B until stop.
    push_wp(8'd0, 32'd11, 16'd1);
    push_wp(8'd1, 32'd22, 16'd1);
    base = got.size();
    wr(16'h0200, 32'h1);
    cycle_i = 6'h3f;
    repeat (40) @(negedge clock);
    wr(16'h0200, 32'h2);
    cycle_i = '0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (got.size() - base < 4) begin
      n_fail++;
      $display("FAIL loop_strobe_count: got %0d, expected at least 4", got.size() - base);
    end
    for (int j = base; j < got.size(); j++)
      chk("loop_value", got[j].value, ((j - base) % 2 == 0) ? 32'd11 : 32'd22);
    rd_chk("loop_fill", 16'h0000, status(0,0,0,2));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
